// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux : routes one valid/ready input stream into two independent FIFOs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic [$clog2(DEPTH):0]   out0_count,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   out1_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]       w_valid;
  logic [1:0]       w_full;
  logic [1:0]       w_oready;
  logic [WIDTH-1:0] w_data [2];
  logic [CW-1:0]    w_cnt  [2];

  assign w_oready = {out1_ready, out0_ready};

  // Readiness looks only at the selected FIFO's stored state, never at in_valid
  // or at a same-cycle pop.
  assign in_ready = ~w_full[in_sel];

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_data[0];
  assign out1_data  = w_data[1];
  assign out0_count = w_cnt[0];
  assign out1_count = w_cnt[1];

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_port
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wptr;
      logic [AW-1:0]    r_rptr;
      logic [CW-1:0]    r_cnt;
      logic             w_push;
      logic             w_pop;

      assign w_push     = in_valid & in_ready & (in_sel == 1'(p));
      assign w_pop      = w_valid[p] & w_oready[p];
      assign w_valid[p] = (r_cnt != '0);
      assign w_full[p]  = (r_cnt == CW'(DEPTH));
      assign w_cnt[p]   = r_cnt;
      // Gate the head with valid so stale storage never shows after reset.
      assign w_data[p]  = w_valid[p] ? r_mem[r_rptr] : '0;

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wptr] <= in_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
          end
          if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux : directed and random checks of stream_demux against queues
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_demux;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [1:0]       out0_count;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [1:0]       out1_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] q0   [$];
  logic [31:0] q1   [$];
  logic [31:0] log0 [$];
  logic [31:0] log1 [$];

  stream_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_count (out0_count),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v0"}, 32'(out0_valid), 32'd0);
    chk({tag, "_v1"}, 32'(out1_valid), 32'd0);
    chk({tag, "_d0"}, out0_data, 32'd0);
    chk({tag, "_d1"}, out1_data, 32'd0);
    chk({tag, "_c0"}, 32'(out0_count), 32'd0);
    chk({tag, "_c1"}, 32'(out1_count), 32'd0);
  endtask

  // One clock cycle: drive, compare against the queue model, advance model at the edge.
  task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1);
    logic exp_rdy;
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready",   32'(in_ready),   32'(exp_rdy));
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out0_data",  out0_data,       (q0.size() != 0) ? q0[0] : 32'd0);
    chk("out0_count", 32'(out0_count), 32'(q0.size()));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    chk("out1_data",  out1_data,       (q1.size() != 0) ? q1[0] : 32'd0);
    chk("out1_count", 32'(out1_count), 32'(q1.size()));
    if (out0_valid && r0) log0.push_back(out0_data);
    if (out1_valid && r1) log1.push_back(out1_data);
    @(posedge clk);
    if (q0.size() != 0 && r0) void'(q0.pop_front());
    if (q1.size() != 0 && r1) void'(q1.pop_front());
    if (v && exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset state, ready for both selects while held in reset
    #2;
    chk_idle("rst");
    chk("rst_rdy_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    chk("rst_rdy_sel1", 32'(in_ready), 32'd1);
    in_sel = 1'b0;
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word to port 0, visible the following cycle
    cycle(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
    #1;
    chk("a5_v0",    32'(out0_valid), 32'd1);
    chk("a5_d0",    out0_data,       32'hA5A5A5A5);
    chk("a5_c0",    32'(out0_count), 32'd1);
    chk("a5_v1",    32'(out1_valid), 32'd0);
    drain();

    // Fill port 1; other port still accepts
    cycle(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    chk("full_c1",  32'(out1_count), 32'd2);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    // Push port 0 while popping full port 1
    cycle(1'b1, 1'b0, 32'h3, 1'b0, 1'b1);
    #1;
    chk("x_d0",     out0_data,       32'h3);
    chk("x_d1",     out1_data,       32'h2);
    chk("x_c1",     32'(out1_count), 32'd1);
    // Refill port 1 then offer a third word while popping: still refused
    cycle(1'b1, 1'b1, 32'h5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h6, 1'b0, 1'b1);
    chk("refuse_c1", 32'(out1_count), 32'd1);
    chk("refuse_d1", out1_data,       32'h5);
    drain();

    // Alternating stream with both consumers ready
    log0.delete(); log1.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'(i), 32'h10 + 32'(i), 1'b1, 1'b1);
    drain();
    chk("alt_n0", 32'(log0.size()), 32'd4);
    chk("alt_n1", 32'(log1.size()), 32'd4);
    for (int i = 0; i < 4 && i < log0.size() && i < log1.size(); i++) begin
      chk("alt_p0", log0[i], 32'h10 + 32'(2 * i));
      chk("alt_p1", log1[i], 32'h11 + 32'(2 * i));
    end

    // Asynchronous reset between edges discards buffered words
    cycle(1'b1, 1'b0, 32'hB0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hB1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    in_sel = 1'b1;
    #1;
    chk("arst_rdy_sel1", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_rst");
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Pointer wrap: ten push/pop pairs through port 0
    log0.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      chk("wrap_cnt_le", 32'(out0_count <= 2'(DEPTH)), 32'd1);
    end
    drain();
    chk("wrap_n", 32'(log0.size()), 32'd10);
    for (int i = 0; i < 10 && i < log0.size(); i++) chk("wrap_order", log0[i], 32'(i));

    // Random traffic against the queue model
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
